// File: rtl/core_icache_pkg.sv
// rtl/core_icache_pkg.sv - shared types and line geometry for the icache refill path
package core_icache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AR,
    R,
    DONE,
    RELEASE
  } refill_state_e;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_resp_e;

  localparam int LINE_BYTES       = 32;
  localparam int LINE_OFFSET_BITS = $clog2(LINE_BYTES);

endpackage

// File: rtl/core_icache_axi_refill.sv
// rtl/core_icache_axi_refill.sv - AXI4 read master refilling one icache line per request
// Define ICACHE_REFILL_ERR_CHK_EN to flag bad rresp/rid/rlast on o_err with o_mem_done.
module core_icache_axi_refill
  import core_icache_pkg::*;
#(
  parameter int ADDR_WIDTH     = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int LINE_WIDTH     = 256,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_ID         = 0
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_mem_req,
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  output logic                      o_mem_done,
  output logic [LINE_WIDTH-1:0]     o_block,
  output logic                      o_err,
  output logic                      o_arvalid,
  input  logic                      i_arready,
  output logic [ADDR_WIDTH-1:0]     o_araddr,
  output logic [7:0]                o_arlen,
  output logic [2:0]                o_arsize,
  output logic [1:0]                o_arburst,
  output logic [AXI_ID_WIDTH-1:0]   o_arid,
  input  logic                      i_rvalid,
  output logic                      o_rready,
  input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]                i_rresp,
  input  logic                      i_rlast,
  input  logic [AXI_ID_WIDTH-1:0]   i_rid
);

  localparam int BEATS  = LINE_WIDTH / AXI_DATA_WIDTH;
  localparam int BEAT_W = $clog2(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  refill_state_e     state;
  logic [BEAT_W-1:0] beat_cnt;
  logic              beat_fire;
  logic              beat_err;
  logic              err;

  assign o_arlen   = 8'(BEATS - 1);
  assign o_arsize  = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign o_arburst = AXI_BURST_INCR;
  assign o_arid    = AXI_ID_WIDTH'(AXI_ID);
  assign beat_fire = i_rvalid & o_rready;

`ifdef ICACHE_REFILL_ERR_CHK_EN
  // rlast must mark exactly the final counted beat; the counter still governs completion.
  assign beat_err = (i_rresp != AXI_RESP_OKAY) | (i_rid != o_arid) |
                    (i_rlast != (beat_cnt == LAST_BEAT));
`else
  logic unused_rchk;
  assign unused_rchk = ^{i_rresp, i_rid, i_rlast};
  assign beat_err    = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      o_block    <= '0;
      o_araddr   <= '0;
      o_arvalid  <= 1'b0;
      o_rready   <= 1'b0;
      o_mem_done <= 1'b0;
      o_err      <= 1'b0;
      err        <= 1'b0;
    end else begin
      o_mem_done <= 1'b0;
      o_err      <= 1'b0;
      case (state)
        IDLE: begin
          err <= 1'b0;
          if (i_mem_req) begin
            o_araddr  <= (i_addr >> LINE_OFFSET_BITS) << LINE_OFFSET_BITS;
            beat_cnt  <= '0;
            o_arvalid <= 1'b1;
            state     <= AR;
          end
        end
        AR: begin
          if (i_arready) begin
            o_arvalid <= 1'b0;
            o_rready  <= 1'b1;
            state     <= R;
          end
        end
        R: begin
          if (beat_fire) begin
            for (int k = 0; k < BEATS; k++) begin
              if (beat_cnt == BEAT_W'(k)) begin
                o_block[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= i_rdata;
              end
            end
            beat_cnt <= beat_cnt + 1'b1;
            err      <= err | beat_err;
            if (beat_cnt == LAST_BEAT) begin
              o_rready   <= 1'b0;
              o_mem_done <= 1'b1;
              o_err      <= err | beat_err;
              state      <= DONE;
            end
          end
        end
        DONE: state <= RELEASE;
        // A request still held high after done must not start a second burst.
        RELEASE: begin
          if (!i_mem_req) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_icache_axi_refill.sv
// tb/tb_core_icache_axi_refill.sv - self-checking bench for core_icache_axi_refill
module tb_core_icache_axi_refill;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mem_req = 1'b0;
  logic [63:0]  addr = '0;
  logic         mem_done;
  logic [255:0] block;
  logic         err;
  logic         arvalid;
  logic         arready = 1'b0;
  logic [63:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic [3:0]   arid;
  logic         rvalid = 1'b0;
  logic         rready;
  logic [63:0]  rdata = '0;
  logic [1:0]   rresp = '0;
  logic         rlast = 1'b0;
  logic [3:0]   rid = '0;

  int checks = 0;
  int errors = 0;

  logic [63:0] bd[4];
  logic [1:0]  br[4];
  logic [3:0]  bi[4];
  logic        bl[4];

  core_icache_axi_refill dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_mem_req(mem_req), .i_addr(addr),
    .o_mem_done(mem_done), .o_block(block), .o_err(err),
    .o_arvalid(arvalid), .i_arready(arready), .o_araddr(araddr), .o_arlen(arlen),
    .o_arsize(arsize), .o_arburst(arburst), .o_arid(arid),
    .i_rvalid(rvalid), .o_rready(rready), .i_rdata(rdata), .i_rresp(rresp),
    .i_rlast(rlast), .i_rid(rid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_err();
    logic e;
    e = 1'b0;
`ifdef ICACHE_REFILL_ERR_CHK_EN
    for (int b = 0; b < 4; b++) begin
      if (br[b] != 2'b00 || bi[b] != 4'd0 || bl[b] != (b == 3)) e = 1'b1;
    end
`endif
    return e;
  endfunction

  task automatic set_beats(input logic inject);
    int kind;
    int beat;
    for (int b = 0; b < 4; b++) begin
      bd[b] = {$urandom, $urandom};
      br[b] = 2'b00;
      bi[b] = 4'd0;
      bl[b] = (b == 3);
    end
    if (inject) begin
      kind = $urandom_range(0, 2);
      beat = $urandom_range(0, 3);
      case (kind)
        0: br[beat] = 2'($urandom_range(1, 3));
        1: bi[beat] = 4'($urandom_range(1, 15));
        default: bl[beat] = ~bl[beat];
      endcase
    end
  endtask

  // One full refill as seen by the AXI slave; rst_at >= 0 resets just after that beat.
  task automatic refill(input logic [63:0] a, input int ar_dly, input int gmin, input int gmax,
                        input int hold, input int rst_at);
    logic [63:0] exp_addr;
    exp_addr = a - (a % 64'd32);
    @(negedge clk);
    mem_req = 1'b1;
    addr    = a;
    @(negedge clk);
    chk("arvalid_rise", 256'(arvalid), 256'(1'b1));
    chk("araddr", 256'(araddr), 256'(exp_addr));
    chk("arlen", 256'(arlen), 256'(8'd3));
    chk("arsize", 256'(arsize), 256'(3'd3));
    chk("arburst", 256'(arburst), 256'(2'b01));
    chk("arid", 256'(arid), 256'(4'd0));
    addr = {$urandom, $urandom};
    repeat (ar_dly) begin
      @(negedge clk);
      chk("arvalid_hold", 256'(arvalid), 256'(1'b1));
      chk("araddr_stable", 256'(araddr), 256'(exp_addr));
    end
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk("arvalid_drop", 256'(arvalid), 256'(1'b0));
    chk("rready_up", 256'(rready), 256'(1'b1));
    for (int b = 0; b < 4; b++) begin
      repeat ($urandom_range(gmin, gmax)) begin
        @(negedge clk);
        chk("rready_gap", 256'(rready), 256'(1'b1));
        chk("done_gap", 256'(mem_done), 256'(1'b0));
      end
      rvalid = 1'b1;
      rdata  = bd[b];
      rresp  = br[b];
      rid    = bi[b];
      rlast  = bl[b];
      @(negedge clk);
      rvalid = 1'b0;
      rlast  = 1'b0;
      chk("done_at_beat", 256'(mem_done), 256'(b == 3));
      if (b == rst_at) begin
        rst_n   = 1'b0;
        mem_req = 1'b0;
        #1;
        chk("rst_arvalid", 256'(arvalid), 256'(1'b0));
        chk("rst_rready", 256'(rready), 256'(1'b0));
        chk("rst_done", 256'(mem_done), 256'(1'b0));
        chk("rst_err", 256'(err), 256'(1'b0));
        chk("rst_block", block, 256'(0));
        chk("rst_araddr", 256'(araddr), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    chk("block", block, {bd[3], bd[2], bd[1], bd[0]});
    chk("err_with_done", 256'(err), 256'(exp_err()));
    chk("rready_done", 256'(rready), 256'(1'b0));
    @(negedge clk);
    chk("done_pulse_end", 256'(mem_done), 256'(1'b0));
    chk("err_clear", 256'(err), 256'(1'b0));
    repeat (hold) begin
      @(negedge clk);
      chk("no_rearm_ar", 256'(arvalid), 256'(1'b0));
      chk("block_held", block, {bd[3], bd[2], bd[1], bd[0]});
    end
    mem_req = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    chk("reset_arvalid", 256'(arvalid), 256'(1'b0));
    chk("reset_rready", 256'(rready), 256'(1'b0));
    chk("reset_done", 256'(mem_done), 256'(1'b0));
    chk("reset_err", 256'(err), 256'(1'b0));
    chk("reset_block", block, 256'(0));
    chk("reset_araddr", 256'(araddr), 256'(0));
    chk("reset_arlen", 256'(arlen), 256'(8'd3));
    rst_n = 1'b1;

    // Directed line 0x1000_0024, data A0..A3 back to back.
    set_beats(1'b0);
    for (int b = 0; b < 4; b++) bd[b] = 64'hA0 + 64'(b);
    refill(64'h1000_0024, 2, 0, 0, 0, -1);

    // Three idle cycles between every beat.
    set_beats(1'b0);
    refill(64'h0000_0000_8000_1F3C, 1, 3, 3, 0, -1);

    // Request held five cycles past done.
    set_beats(1'b0);
    refill(64'hDEAD_BEEF_0000_0041, 0, 0, 1, 5, -1);

    // Reset after beat 1, then a fresh burst.
    set_beats(1'b0);
    refill(64'h0000_0000_0000_2000, 0, 0, 1, 0, 1);
    set_beats(1'b0);
    refill(64'h0000_0000_0000_3018, 1, 0, 2, 0, -1);

    // SLVERR on beat 2.
    set_beats(1'b0);
    br[2] = 2'b10;
    refill(64'h0000_0000_4000_0000, 0, 0, 1, 1, -1);

    // Early rlast on beat 1: completion still after four beats.
    set_beats(1'b0);
    bl[1] = 1'b1;
    refill(64'h0000_0000_4000_0060, 1, 0, 1, 0, -1);

    for (int n = 0; n < 10; n++) begin
      set_beats(1'($urandom_range(0, 1)));
      refill({$urandom, $urandom}, $urandom_range(0, 3), 0, 3, $urandom_range(0, 3), -1);
    end

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
